// File: rtl/fp_pkg.sv
// Shared floating-point widths, constants and the scheduler state encoding.
package fp_pkg;
  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/fp_adder_scheduler_if.sv
// Request/response bundle between the arithmetic clients and the shared adder scheduler.
interface fp_adder_scheduler_if
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][FP_W-1:0] req_x;
  logic [NUM_REQ-1:0][FP_W-1:0] req_y;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [FP_W-1:0]              rsp_result;
  logic                         rsp_overflow;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/floatingPointAdder.sv
// Combinational IEEE-754 single adder: truncating, denormals flushed to zero,
// canonical quiet NaN out, overflow flag when a finite sum exceeds the range.
module floatingPointAdder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] x,
  input  logic [FP_W-1:0] y,
  output logic [FP_W-1:0] result,
  output logic            overflow
);
  // hidden bit + mantissa + 3 guard bits keep subtraction from losing the low bits early
  localparam int SIG_W = MAN_W + 4;

  logic [FP_W-1:0]        a, b;
  logic                   x_nan, y_nan, x_inf, y_inf, sa, sb, found;
  logic [EXP_W-1:0]       ea, eb, d;
  logic [SIG_W-1:0]       al, bl, bs, norm;
  logic [SIG_W:0]         sum;
  logic [4:0]             lz;
  logic signed [EXP_W+1:0] e;
  logic [MAN_W-1:0]       man;
  logic                   unused_bits;

  always_comb begin
    x_nan = (&x[30:23]) & (|x[22:0]);
    y_nan = (&y[30:23]) & (|y[22:0]);
    x_inf = (&x[30:23]) & ~(|x[22:0]);
    y_inf = (&y[30:23]) & ~(|y[22:0]);
    if (y[30:0] > x[30:0]) begin
      a = y;
      b = x;
    end else begin
      a = x;
      b = y;
    end
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    al = (ea == '0) ? '0 : {1'b1, a[22:0], 3'b000};
    bl = (eb == '0) ? '0 : {1'b1, b[22:0], 3'b000};
    d  = ea - eb;
    bs = bl >> d;
    sum = (sa == sb) ? ({1'b0, al} + {1'b0, bs}) : ({1'b0, al} - {1'b0, bs});

    lz    = '0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + 5'd1;
      end
    end
    norm = sum[SIG_W-1:0] << lz;

    if (sum[SIG_W]) begin
      e   = $signed({2'b00, ea}) + 10'sd1;
      man = sum[SIG_W-1:4];
    end else begin
      e   = $signed({2'b00, ea}) - $signed({5'b00000, lz});
      man = norm[SIG_W-2:3];
    end

    result   = {sa, e[EXP_W-1:0], man};
    overflow = 1'b0;
    if (x_nan | y_nan | (x_inf & y_inf & (x[31] ^ y[31]))) begin
      result = FP_QNAN;
    end else if (x_inf) begin
      result = x;
    end else if (y_inf) begin
      result = y;
    end else if (sum == '0 || e <= 10'sd0) begin
      result = {sa & sb, 31'd0};
    end else if (e >= 10'sd255) begin
      result   = FP_POS_INF | {sa, 31'd0};
      overflow = 1'b1;
    end
  end

  assign unused_bits = ^{norm[SIG_W-1], norm[2:0]};
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);
  int              cand;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    cand      = 0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      idx = ID_W'(cand);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end
endmodule

// File: rtl/fp_adder_scheduler.sv
// Time-shares one floatingPointAdder among NUM_REQ requesters with round-robin
// grants; one transaction in flight, response tagged with the owner index.
module fp_adder_scheduler
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_adder_scheduler_if.slave  bus,
  output logic                 busy
);
  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant, cur_id, win_id;
  logic [NUM_REQ-1:0]  win_oh;
  logic                any_win, hs;
  logic [FP_W-1:0]     op_x, op_y, sum;
  logic                sum_ovf;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (win_oh),
    .grant_id   (win_id),
    .any_grant  (any_win)
  );

  floatingPointAdder u_add (
    .x        (op_x),
    .y        (op_y),
    .result   (sum),
    .overflow (sum_ovf)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ready is only offered from IDLE, so every grant is a handshake.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    hs            = 1'b0;
    case (state)
      IDLE: if (!rst) begin
        bus.req_ready = win_oh;
        hs            = any_win;
        if (any_win) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant       <= ID_W'(NUM_REQ - 1);
      cur_id           <= '0;
      op_x             <= '0;
      op_y             <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
    end else begin
      if (hs) begin
        op_x       <= bus.req_x[win_id];
        op_y       <= bus.req_y[win_id];
        cur_id     <= win_id;
        last_grant <= win_id;
      end
      if (state == EXEC) begin
        bus.rsp_valid    <= 1'b1;
        bus.rsp_id       <= cur_id;
        bus.rsp_result   <= sum;
        bus.rsp_overflow <= sum_ovf;
      end
      if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_adder_scheduler.sv
// Directed bench for fp_adder_scheduler: arbitration order, latency, backpressure,
// special values, reset mid-operation and pointer wrap.
module tb_fp_adder_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  int          order[6] = '{0, 1, 2, 3, 0, 1};
  logic [31:0] fx[5]    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  fp_adder_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  fp_adder_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction with rsp_ready held high: grant, EXEC, RESP, back to IDLE.
  task automatic do_op(input logic [1:0] id, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r, input logic exp_o);
    logic [3:0] rdy;
    rdy = 4'b0001 << id;
    @(negedge clk);
    bus.rsp_ready     = 1'b1;
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_x[id]     = x;
    bus.req_y[id]     = y;
    #1 chk("op_ready", 32'(bus.req_ready), 32'(rdy));
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("op_exec_vld", 32'(bus.rsp_valid), 0);
    chk("op_exec_busy", 32'(busy), 1);
    @(negedge clk);
    #1 chk("op_vld", 32'(bus.rsp_valid), 1);
    chk("op_id", 32'(bus.rsp_id), 32'(id));
    chk("op_res", bus.rsp_result, exp_r);
    chk("op_ovf", 32'(bus.rsp_overflow), 32'(exp_o));
    @(negedge clk);
    #1 chk("op_idle_busy", 32'(busy), 0);
    chk("op_idle_vld", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int g, r, last_k;
    bus.req_valid = 4'b0001;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;

    // reset state; a pending request must not see ready while in reset
    repeat (2) @(negedge clk);
    #1 chk("rst_vld", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_id", 32'(bus.rsp_id), 0);
    chk("rst_res", bus.rsp_result, 0);
    chk("rst_ovf", 32'(bus.rsp_overflow), 0);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = '0;

    // round-robin with everyone valid
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_x[i] = fx[i];
      bus.req_y[i] = 32'h3F800000;
    end
    bus.req_valid = '1;
    g = 0; r = 0; last_k = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (bus.req_ready != '0 && g < 6) begin
        chk("rr_grant", 32'(bus.req_ready), 32'(1) << order[g]);
        if (g > 0) chk("rr_gap", 32'(k - last_k), 3);
        last_k = k;
        g++;
      end
      if (bus.rsp_valid && r < 6) begin
        chk("rr_id", 32'(bus.rsp_id), 32'(order[r]));
        chk("rr_res", bus.rsp_result, fx[order[r] + 1]);
        r++;
      end
    end
    chk("rr_ngrant", 32'(g), 6);
    chk("rr_nrsp", 32'(r), 6);
    @(negedge clk);
    bus.req_valid = '0;

    // single request: 1.0 + 2.0
    do_op(2'd2, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);

    // backpressure on 1.0 + -1.0 while requester 3 waits
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_x[0]  = 32'h3F800000;
    bus.req_y[0]  = 32'hBF800000;
    #1 chk("bp_ready0", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    bus.req_valid[3] = 1'b1;
    bus.req_x[3]     = 32'h40000000;
    bus.req_y[3]     = 32'h40000000;
    #1 chk("bp_id", 32'(bus.rsp_id), 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("bp_vld", 32'(bus.rsp_valid), 1);
      chk("bp_res", bus.rsp_result, 32'h00000000);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_vld", 32'(bus.rsp_valid), 0);
    chk("bp_next_ready", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1 chk("bp_next_id", 32'(bus.rsp_id), 3);
    chk("bp_next_res", bus.rsp_result, 32'h40800000);

    // special values and overflow
    do_op(2'd1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
    do_op(2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0);
    do_op(2'd2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);

    // reset in EXEC after granting requester 1; pointer must return to 3
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_x[1]  = 32'h3F800000;
    bus.req_y[1]  = 32'h3F800000;
    @(negedge clk);
    bus.req_valid = '0;
    rst           = 1'b1;
    #1 chk("mid_busy", 32'(busy), 1);
    @(negedge clk);
    #1 chk("mid_vld", 32'(bus.rsp_valid), 0);
    chk("mid_idle", 32'(busy), 0);
    rst           = 1'b0;
    bus.req_valid = 4'b1010;
    #1 chk("mid_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1 chk("mid_id", 32'(bus.rsp_id), 1);
    chk("mid_res", bus.rsp_result, 32'h40000000);

    // pointer wrap: 3, 3, then 0 beats 3
    do_op(2'd3, 32'h40000000, 32'h3F800000, 32'h40400000, 1'b0);
    do_op(2'd3, 32'h40400000, 32'h3F800000, 32'h40800000, 1'b0);
    @(negedge clk);
    bus.req_valid = 4'b1001;
    bus.req_x[0]  = 32'h40800000;
    bus.req_y[0]  = 32'h3F800000;
    #1 chk("wrap_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1 chk("wrap_id", 32'(bus.rsp_id), 0);
    chk("wrap_res", bus.rsp_result, 32'h40A00000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
